// File: rtl/hazard_pipe_ctrl.sv
// Destination-tag pipeline (EX/MEM/WB) feeding operand forwarding, with load-use
// interlock, branch-flush bubbles, global memory-wait freeze and a stall counter.
module hazard_pipe_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_id,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic [REG_W-1:0] rd_id,
    input  logic             GPRWr_id,
    input  logic             lw_id,
    input  logic             flush,
    input  logic             mem_wait,
    input  logic             cnt_clr,
    output logic [REG_W-1:0] rdEX,
    output logic [REG_W-1:0] rdMEM,
    output logic [REG_W-1:0] rdWB,
    output logic             GPRWrEX,
    output logic             GPRWrMEM,
    output logic             GPRWrWB,
    output logic             lwEX,
    output logic             lwMEM,
    output logic             stall,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [REG_W-1:0] ZERO_REG = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [REG_W-1:0] rd_ex_q,  rd_ex_d;
    logic [REG_W-1:0] rd_mem_q, rd_mem_d;
    logic [REG_W-1:0] rd_wb_q,  rd_wb_d;
    logic             wr_ex_q,  wr_ex_d;
    logic             wr_mem_q, wr_mem_d;
    logic             wr_wb_q,  wr_wb_d;
    logic             lw_ex_q,  lw_ex_d;
    logic             lw_mem_q, lw_mem_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    logic wr_in;
    logic lw_in;
    logic lu;
    logic src_hit;

    // ID-stage qualification: writes to $0 are dropped before they enter the pipe
    assign wr_in   = valid_id & GPRWr_id & (rd_id != ZERO_REG);
    assign lw_in   = valid_id & lw_id & wr_in;
    assign src_hit = (use_rs & (rs_id == rd_ex_q)) | (use_rt & (rt_id == rd_ex_q));
    assign lu      = valid_id & lw_ex_q & wr_ex_q & (rd_ex_q != ZERO_REG) & src_hit;

    // mem_wait dominates: flush and load-use are deferred until the freeze lifts
    assign stall   = mem_wait | lu;
    assign bubble  = ~mem_wait & (lu | flush);

    always_comb begin
        rd_ex_d  = rd_ex_q;
        wr_ex_d  = wr_ex_q;
        lw_ex_d  = lw_ex_q;
        rd_mem_d = rd_mem_q;
        wr_mem_d = wr_mem_q;
        lw_mem_d = lw_mem_q;
        rd_wb_d  = rd_wb_q;
        wr_wb_d  = wr_wb_q;
        if (!mem_wait) begin
            rd_mem_d = rd_ex_q;
            wr_mem_d = wr_ex_q;
            lw_mem_d = lw_ex_q;
            rd_wb_d  = rd_mem_q;
            wr_wb_d  = wr_mem_q;
            if (bubble) begin
                rd_ex_d = ZERO_REG;
                wr_ex_d = 1'b0;
                lw_ex_d = 1'b0;
            end else begin
                rd_ex_d = rd_id;
                wr_ex_d = wr_in;
                lw_ex_d = lw_in;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (stall) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ex_q  <= '0;
            wr_ex_q  <= 1'b0;
            lw_ex_q  <= 1'b0;
            rd_mem_q <= '0;
            wr_mem_q <= 1'b0;
            lw_mem_q <= 1'b0;
            rd_wb_q  <= '0;
            wr_wb_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            rd_ex_q  <= rd_ex_d;
            wr_ex_q  <= wr_ex_d;
            lw_ex_q  <= lw_ex_d;
            rd_mem_q <= rd_mem_d;
            wr_mem_q <= wr_mem_d;
            lw_mem_q <= lw_mem_d;
            rd_wb_q  <= rd_wb_d;
            wr_wb_q  <= wr_wb_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rdEX      = rd_ex_q;
    assign rdMEM     = rd_mem_q;
    assign rdWB      = rd_wb_q;
    assign GPRWrEX   = wr_ex_q;
    assign GPRWrMEM  = wr_mem_q;
    assign GPRWrWB   = wr_wb_q;
    assign lwEX      = lw_ex_q;
    assign lwMEM     = lw_mem_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Directed-vector bench for hazard_pipe_ctrl; a second instance with a 4-bit
// counter exercises stall_cnt saturation.
module tb_hazard_pipe_ctrl;

    logic       clk;
    logic       rst_n;
    logic       valid_id;
    logic [4:0] rs_id, rt_id, rd_id;
    logic       use_rs, use_rt, GPRWr_id, lw_id;
    logic       flush, mem_wait, cnt_clr;

    logic [4:0]  rdEX, rdMEM, rdWB;
    logic        GPRWrEX, GPRWrMEM, GPRWrWB, lwEX, lwMEM, stall, bubble;
    logic [15:0] stall_cnt;

    logic [4:0]  s_rdEX, s_rdMEM, s_rdWB;
    logic        s_GPRWrEX, s_GPRWrMEM, s_GPRWrWB, s_lwEX, s_lwMEM, s_stall, s_bubble;
    logic [3:0]  s_cnt;

    int n_vec;
    int n_err;

    hazard_pipe_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs(use_rs), .use_rt(use_rt), .rd_id(rd_id), .GPRWr_id(GPRWr_id),
        .lw_id(lw_id), .flush(flush), .mem_wait(mem_wait), .cnt_clr(cnt_clr),
        .rdEX(rdEX), .rdMEM(rdMEM), .rdWB(rdWB), .GPRWrEX(GPRWrEX),
        .GPRWrMEM(GPRWrMEM), .GPRWrWB(GPRWrWB), .lwEX(lwEX), .lwMEM(lwMEM),
        .stall(stall), .bubble(bubble), .stall_cnt(stall_cnt)
    );

    hazard_pipe_ctrl #(.REG_W(5), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs(use_rs), .use_rt(use_rt), .rd_id(rd_id), .GPRWr_id(GPRWr_id),
        .lw_id(lw_id), .flush(flush), .mem_wait(mem_wait), .cnt_clr(cnt_clr),
        .rdEX(s_rdEX), .rdMEM(s_rdMEM), .rdWB(s_rdWB), .GPRWrEX(s_GPRWrEX),
        .GPRWrMEM(s_GPRWrMEM), .GPRWrWB(s_GPRWrWB), .lwEX(s_lwEX), .lwMEM(s_lwMEM),
        .stall(s_stall), .bubble(s_bubble), .stall_cnt(s_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_instr(input logic [4:0] rd, input logic wr, input logic lw,
                            input logic [4:0] rs, input logic urs,
                            input logic [4:0] rt, input logic urt);
        valid_id = 1'b1;
        rd_id    = rd;
        GPRWr_id = wr;
        lw_id    = lw;
        rs_id    = rs;
        use_rs   = urs;
        rt_id    = rt;
        use_rt   = urt;
        #1;
    endtask

    task automatic id_idle();
        valid_id = 1'b0;
        rd_id    = 5'd0;
        GPRWr_id = 1'b0;
        lw_id    = 1'b0;
        rs_id    = 5'd0;
        use_rs   = 1'b0;
        rt_id    = 5'd0;
        use_rt   = 1'b0;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdEX"},  32'(rdEX),  32'd0);
        chk({tag, "_rdMEM"}, 32'(rdMEM), 32'd0);
        chk({tag, "_rdWB"},  32'(rdWB),  32'd0);
        chk({tag, "_wr"},    32'({GPRWrEX, GPRWrMEM, GPRWrWB}), 32'd0);
        chk({tag, "_lw"},    32'({lwEX, lwMEM}), 32'd0);
        chk({tag, "_cnt"},   32'(stall_cnt), 32'd0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        mem_wait = 1'b0;
        cnt_clr  = 1'b0;
        id_idle();

        // reset state
        #10;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // load-use: lw r8, then add using r8
        id_instr(5'd8, 1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1);
        chk("lu_pre_stall", 32'(stall), 32'd0);
        tick();
        chk("lu_lwEX", 32'(lwEX), 32'd1);
        id_instr(5'd9, 1'b1, 1'b0, 5'd8, 1'b1, 5'd3, 1'b0);
        chk("lu_stall",  32'(stall),  32'd1);
        chk("lu_bubble", 32'(bubble), 32'd1);
        tick();
        chk("lu_GPRWrEX", 32'(GPRWrEX), 32'd0);
        chk("lu_rdMEM",   32'(rdMEM),   32'd8);
        chk("lu_lwMEM",   32'(lwMEM),   32'd1);
        chk("lu_stall_end", 32'(stall), 32'd0);
        tick();
        chk("lu_rdEX_add", 32'(rdEX), 32'd9);
        chk("lu_rdWB",     32'(rdWB), 32'd8);
        chk("lu_cnt",      32'(stall_cnt), 32'd1);

        // write to $0 never propagates
        id_instr(5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("r0_GPRWrEX", 32'(GPRWrEX), 32'd0);
        id_instr(5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("r0_GPRWrMEM", 32'(GPRWrMEM), 32'd0);
        chk("r0_next_rdEX", 32'(rdEX), 32'd3);
        id_idle();
        tick();
        chk("r0_GPRWrWB", 32'(GPRWrWB), 32'd0);
        chk("r0_rdMEM", 32'(rdMEM), 32'd3);

        // fill pipe, then freeze 3 cycles with a pending flush
        for (int i = 10; i <= 12; i++) begin
            id_instr(5'(i), 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
            tick();
        end
        id_instr(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        mem_wait = 1'b1;
        flush    = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("mw_stall",  32'(stall),  32'd1);
            chk("mw_bubble", 32'(bubble), 32'd0);
            tick();
        end
        chk("mw_rd",  32'({rdEX, rdMEM, rdWB}), 32'({5'd12, 5'd11, 5'd10}));
        chk("mw_wr",  32'({GPRWrEX, GPRWrMEM, GPRWrWB}), 32'd7);
        chk("mw_cnt", 32'(stall_cnt), 32'd4);

        // flush accepted on the first cycle after the freeze
        mem_wait = 1'b0;
        #1;
        chk("fl_stall",  32'(stall),  32'd0);
        chk("fl_bubble", 32'(bubble), 32'd1);
        tick();
        chk("fl_rdEX",    32'(rdEX),    32'd0);
        chk("fl_GPRWrEX", 32'(GPRWrEX), 32'd0);
        chk("fl_rdMEM",   32'(rdMEM),   32'd12);
        chk("fl_rdWB",    32'(rdWB),    32'd11);
        flush = 1'b0;

        // asynchronous reset mid-stream
        id_instr(5'd14, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("ar_pre_rdEX", 32'(rdEX), 32'd14);
        id_instr(5'd20, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        rst_n = 1'b1;
        tick();
        chk("ar_rdEX",    32'(rdEX),    32'd20);
        chk("ar_GPRWrEX", 32'(GPRWrEX), 32'd1);
        chk("ar_rdMEM",   32'(rdMEM),   32'd0);

        // counter saturation on the 4-bit instance, then clear
        id_idle();
        cnt_clr = 1'b1;
        tick();
        chk("sat_clr0", 32'(s_cnt), 32'd0);
        cnt_clr  = 1'b0;
        mem_wait = 1'b1;
        repeat (20) tick();
        chk("sat_cnt15", 32'(s_cnt), 32'd15);
        chk("sat_cnt20", 32'(stall_cnt), 32'd20);
        cnt_clr = 1'b1;
        tick();
        chk("sat_clr", 32'(s_cnt), 32'd0);
        chk("cnt_clr", 32'(stall_cnt), 32'd0);
        cnt_clr  = 1'b0;
        mem_wait = 1'b0;
        tick();
        chk("cnt_idle", 32'(stall_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
